cardinal_nic: RTL
=================

# cardinal_nic

Network interface controller that sits between one cardinal processor's NIC port and its ring router's local port. It answers the processor's 2-bit register-addressed NIC accesses. It holds one 64-bit packet in each direction and performs the ready/valid handshake with the router. The top level uses one instance per node (four total).

## Interface
- DATA_WIDTH, 64, packet and register width; bit 0 is MSB, bit 0 of a packet is its virtual-channel (VC) bit
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- addr_nic  in  [0:1]  register select from processor
- din_nic  in  [0:63]  write data from processor
- dout_nic  out  [0:63]  read data to processor
- nicEn  in  1  access enable from processor
- nicWrEn  in  1  1 = write, 0 = read (qualified by nicEn)
- net_si  in  1  router has a packet for this node
- net_ri  out  1  NIC can accept a packet from router
- net_di  in  [0:63]  packet from router
- net_so  out  1  NIC is sending a packet to router
- net_ro  in  1  router can accept a packet
- net_do  out  [0:63]  packet to router
- net_polarity  in  1  router's current VC polarity

## Operation
- State:
  - in_buf[0:63] with in_full flag.
  - out_buf[0:63] with out_full flag.
- Register map:
  - 2'b00 input buffer (read clears).
  - 2'b01 input status, bit 63 = in_full, other bits 0.
  - 2'b10 output buffer (write only; reads return 0).
  - 2'b11 output status, bit 63 = out_full, other bits 0.
- Processor read (nicEn=1, nicWrEn=0):
  - dout_nic is combinational from the addressed register.
  - A read of 2'b00 with in_full=1 clears in_full at the edge; in_buf is held.
  - A read of 2'b00 with in_full=0 returns the stale in_buf and changes no state.
- dout_nic = 0 whenever nicEn=0 or nicWrEn=1.
- Processor write (nicEn=1, nicWrEn=1):
  - Addr 2'b10 with out_full=0: out_buf <= din_nic and out_full <= 1.
  - Addr 2'b10 with out_full=1: write silently dropped.
  - Writes to 00, 01, 11: ignored.
- Receive: net_ri = reset & ~in_full. When net_si & net_ri, at the edge in_buf <= net_di and in_full <= 1.
- Transmit:
  - net_so = out_full & net_ro & (out_buf[0] == net_polarity), combinational.
  - net_do = out_buf always.
  - When net_so=1, out_full clears at that edge.
- Simultaneous events:
  - A processor write to 2'b10 in the same cycle net_so=1 is dropped, because out_full was 1 when sampled.
  - A processor read of 2'b00 and a router delivery cannot coincide: net_ri=0 while in_full=1.
  - Read-clear and a new receive are therefore never in the same cycle.

## Timing
- Reset values:
  - in_buf, out_buf, in_full, out_full = 0.
  - net_ri = 0 while reset low, 1 after release.
  - net_so = 0; net_do = 0; dout_nic = 0.
- Read latency: 0 cycles (combinational); state side effect at the next edge.
- Write to out_buf → net_so may assert the following cycle (1-cycle minimum).
- Router delivery → in_full=1 and status readable the following cycle; net_ri drops the same following cycle.
- Read-clear of in_full → net_ri=1 the following cycle.
- Back-to-back throughput is one packet per 2 cycles per direction (single buffer, fill then drain).
- Reset asserted mid-transfer: flags clear immediately (asynchronous) and any buffered packet is lost. net_so and net_ri drop combinationally with the flags.

## Test plan
- Reset, then read addr 01 and addr 11 → both 64'h0; net_ri=1, net_so=0.
- Set net_polarity=1 and net_ro=1, then write 64'h8000_0000_0000_00AB to addr 10:
  - net_so=1 next cycle with net_do=64'h8000_0000_0000_00AB.
  - Addr 11 reads 0 the cycle after.
- Same packet with net_polarity=0:
  - net_so stays 0 and addr 11 reads 64'h1.
  - Flip net_polarity to 1 → sent in that cycle.
  - A second write issued while still full is dropped, and the original data is sent.
- Pulse net_si with net_di=64'h0123_4567_89AB_CDEF:
  - net_ri=0 next cycle; addr 01 reads 64'h1.
  - A second net_si is held off.
  - Read addr 00 → 64'h0123_4567_89AB_CDEF; net_ri=1 on the next cycle.
- With out_full=1 and in_full=1, assert reset low mid-cycle → flags clear immediately, net_so=0, net_ri=0; after release, net_ri=1.

Source files
------------

// File: rtl/cardinal_nic_if.sv
// ---------------------------------------------------------------------------
// cardinal_nic_if
//
// Bundles the two buses that meet at a cardinal NIC:
//   * processor side : addr_nic, din_nic, dout_nic, nicEn, nicWrEn
//   * router side    : net_si/net_ri/net_di (router -> NIC)
//                      net_so/net_ro/net_do (NIC -> router), net_polarity
//
// Vectors use big-endian bit numbering: bit 0 is the MSB, and bit 0 of a
// packet is its virtual-channel bit.
//
// Modports:
//   slave  - the NIC itself (receives accesses and packets, drives responses)
//   master - the environment (processor + router) driving the NIC
// ---------------------------------------------------------------------------
interface cardinal_nic_if #(
    parameter int DATA_WIDTH = 64
);
    // Processor register port
    logic [0:1]            addr_nic;
    logic [0:DATA_WIDTH-1] din_nic;
    logic [0:DATA_WIDTH-1] dout_nic;
    logic                  nicEn;
    logic                  nicWrEn;

    // Router -> NIC
    logic                  net_si;
    logic                  net_ri;
    logic [0:DATA_WIDTH-1] net_di;

    // NIC -> router
    logic                  net_so;
    logic                  net_ro;
    logic [0:DATA_WIDTH-1] net_do;
    logic                  net_polarity;

    modport slave (
        input  addr_nic, din_nic, nicEn, nicWrEn,
        input  net_si, net_di, net_ro, net_polarity,
        output dout_nic, net_ri, net_so, net_do
    );

    modport master (
        output addr_nic, din_nic, nicEn, nicWrEn,
        output net_si, net_di, net_ro, net_polarity,
        input  dout_nic, net_ri, net_so, net_do
    );
endinterface

// File: rtl/cardinal_nic.sv
// ---------------------------------------------------------------------------
// cardinal_nic
//
// Network interface between one cardinal processor and the local port of
// its ring router. Holds a single packet in each direction.
//
// Ports:
//   clk    - system clock, all state updates on the rising edge
//   reset  - asynchronous, active-low; clears all state while low
//   bus    - cardinal_nic_if.slave (processor register port + router port)
//
// Register map (addr_nic):
//   2'b00  input buffer   read returns in_buf; a read while full clears in_full
//   2'b01  input status   bit 63 = in_full
//   2'b10  output buffer  write-only; accepted only when out_full = 0
//   2'b11  output status  bit 63 = out_full
// ---------------------------------------------------------------------------
module cardinal_nic (
    input  logic            clk,
    input  logic            reset,
    cardinal_nic_if.slave   bus
);
    localparam int DW = $bits(bus.din_nic);

    localparam logic [1:0] ADDR_IN_BUF     = 2'b00;
    localparam logic [1:0] ADDR_IN_STATUS  = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF    = 2'b10;
    localparam logic [1:0] ADDR_OUT_STATUS = 2'b11;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [0:DW-1] in_buf_q,   in_buf_d;
    logic          in_full_q,  in_full_d;
    logic [0:DW-1] out_buf_q,  out_buf_d;
    logic          out_full_q, out_full_d;

    // -----------------------------------------------------------------------
    // Decoded processor access
    // -----------------------------------------------------------------------
    logic [1:0] addr;
    logic       rd_en;
    logic       wr_en;

    assign addr  = bus.addr_nic;
    assign rd_en = bus.nicEn & ~bus.nicWrEn;
    assign wr_en = bus.nicEn &  bus.nicWrEn;

    // -----------------------------------------------------------------------
    // Router handshakes
    // -----------------------------------------------------------------------
    logic recv_fire;
    logic send_fire;
    logic vc_match;

    // Only packets whose VC bit matches the router's current polarity may go.
    assign vc_match  = (out_buf_q[0] == bus.net_polarity);
    assign send_fire = out_full_q & bus.net_ro & vc_match;

    // Gating with reset keeps net_ri low during reset even though the flag
    // is already cleared.
    assign bus.net_ri = reset & ~in_full_q;
    assign bus.net_so = send_fire;
    assign bus.net_do = out_buf_q;
    assign recv_fire  = bus.net_si & bus.net_ri;

    // -----------------------------------------------------------------------
    // Processor read data (combinational)
    // -----------------------------------------------------------------------
    always_comb begin
        bus.dout_nic = '0;
        if (rd_en) begin
            unique case (addr)
                ADDR_IN_BUF:     bus.dout_nic = in_buf_q;
                ADDR_IN_STATUS:  bus.dout_nic = {{(DW-1){1'b0}}, in_full_q};
                ADDR_OUT_BUF:    bus.dout_nic = '0;
                ADDR_OUT_STATUS: bus.dout_nic = {{(DW-1){1'b0}}, out_full_q};
                default:         bus.dout_nic = '0;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        in_buf_d   = in_buf_q;
        in_full_d  = in_full_q;
        out_buf_d  = out_buf_q;
        out_full_d = out_full_q;

        // Receive and read-clear are mutually exclusive: recv_fire needs
        // in_full = 0, read-clear needs in_full = 1. in_buf is kept on a
        // read so a later read of an empty buffer returns the stale packet.
        if (recv_fire) begin
            in_buf_d  = bus.net_di;
            in_full_d = 1'b1;
        end else if (rd_en && (addr == ADDR_IN_BUF) && in_full_q) begin
            in_full_d = 1'b0;
        end

        // A write racing a send sees out_full = 1 and is dropped; the buffer
        // only frees up at this edge.
        if (send_fire) begin
            out_full_d = 1'b0;
        end else if (wr_en && (addr == ADDR_OUT_BUF) && !out_full_q) begin
            out_buf_d  = bus.din_nic;
            out_full_d = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_buf_q   <= '0;
            in_full_q  <= 1'b0;
            out_buf_q  <= '0;
            out_full_q <= 1'b0;
        end else begin
            in_buf_q   <= in_buf_d;
            in_full_q  <= in_full_d;
            out_buf_q  <= out_buf_d;
            out_full_q <= out_full_d;
        end
    end

endmodule
